// File: rtl/arrow_draw_sequencer_if.sv
// Request channel from the game logic into the arrow draw sequencer.
// The game logic drives a request and the sequencer answers with req_ready.
interface arrow_draw_sequencer_if;
    logic       req_valid;
    logic [1:0] req_dir;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_dir,
        output req_x,
        output req_y,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dir,
        input  req_x,
        input  req_y,
        output req_ready
    );
endinterface

// File: rtl/arrow_draw_sequencer.sv
// Arrow draw sequencer: queues arrow requests and hands them one at a time
// to the up/down/left/right sprite drawers, waiting for each draw to finish.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no draw active; pops the FIFO head when a request is queued
// START | start pulse for the selected drawer is high this cycle
// ARM   | waiting for the selected done to fall (bounded by ARM_TIMEOUT)
// WAIT  | drawer running; waiting for the selected done to rise again
module arrow_draw_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ARM_TIMEOUT = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    arrow_draw_sequencer_if.slave    req,
    output logic                     start_up,
    output logic                     start_down,
    output logic                     start_left,
    output logic                     start_right,
    output logic [7:0]               refX,
    output logic [6:0]               refY,
    input  logic                     done_up,
    input  logic                     done_down,
    input  logic                     done_left,
    input  logic                     done_right,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_done,
    output logic                     arm_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic [16:0]   head;

    logic [1:0]    state;
    logic [1:0]    dir_q;
    logic [3:0]    start_vec;
    logic [TW-1:0] arm_tmr;
    logic          done_sel;

    assign full          = (count == CW'(DEPTH));
    assign req.req_ready = ~full;
    // Full is decided on the registered count, so a pop on the same edge
    // never frees room for a push.
    assign push          = req.req_valid && !full;
    assign pop           = (state == S_IDLE) && (count != '0);
    assign head          = mem[rd_ptr];

    assign {start_right, start_left, start_down, start_up} = start_vec;

    // Select the done line of the drawer owning the active draw.
    always_comb begin
        done_sel = done_up;
        case (dir_q)
            2'd0:    done_sel = done_up;
            2'd1:    done_sel = done_down;
            2'd2:    done_sel = done_left;
            default: done_sel = done_right;
        endcase
    end

    // FIFO storage; needs no reset because the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {req.req_dir, req.req_x, req.req_y};
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Dispatch FSM with registered start pulses, references and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            dir_q      <= 2'd0;
            start_vec  <= 4'b0000;
            refX       <= 8'd0;
            refY       <= 7'd0;
            arm_tmr    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            arm_err    <= 1'b0;
        end else begin
            start_vec  <= 4'b0000;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        dir_q     <= head[16:15];
                        refX      <= head[14:7];
                        refY      <= head[6:0];
                        start_vec <= 4'b0001 << head[16:15];
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    arm_tmr <= TW'(ARM_TIMEOUT);
                    state   <= S_ARM;
                end
                S_ARM: begin
                    if (!done_sel) begin
                        state <= S_WAIT;
                    end else if (arm_tmr == TW'(1)) begin
                        // Drawer never acknowledged; treat the draw as finished.
                        arm_err    <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= (count == '0) && !push;
                        state      <= S_IDLE;
                    end else begin
                        arm_tmr <= arm_tmr - 1'b1;
                    end
                end
                default: begin
                    if (done_sel) begin
                        busy       <= 1'b0;
                        frame_done <= (count == '0) && !push;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arrow_draw_sequencer.sv
// Bench for arrow_draw_sequencer: behavioural drawer model plus a scoreboard
// of expected dispatches {dir, x, y} checked at every start pulse.
module tb_arrow_draw_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       su, sd, sl, sr;
    logic [7:0] refx;
    logic [6:0] refy;
    logic [3:0] done_r;
    logic       busy, fd, ae;
    logic [2:0] cnt;
    logic [1:0] sdir;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    arrow_draw_sequencer_if rif ();

    arrow_draw_sequencer #(.DEPTH(4), .ARM_TIMEOUT(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (rif),
        .start_up   (su),
        .start_down (sd),
        .start_left (sl),
        .start_right(sr),
        .refX       (refx),
        .refY       (refy),
        .done_up    (done_r[0]),
        .done_down  (done_r[1]),
        .done_left  (done_r[2]),
        .done_right (done_r[3]),
        .busy       (busy),
        .count      (cnt),
        .frame_done (fd),
        .arm_err    (ae)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign sdir = sr ? 2'd3 : sl ? 2'd2 : sd ? 2'd1 : 2'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drawer model: done falls one cycle after start, rises 66 cycles after start.
    logic stall = 1'b0;
    logic nofall = 1'b0;
    int   dcnt;
    logic [1:0] act;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 4'hF;
            dcnt   <= 0;
            act    <= 2'd0;
        end else if ((su | sd | sl | sr) && !nofall) begin
            act          <= sdir;
            done_r[sdir] <= 1'b0;
            dcnt         <= 65;
        end else if (dcnt != 0 && !stall) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) done_r[act] <= 1'b1;
        end
    end

    // Scoreboard and dispatch monitor.
    logic [16:0] sb[$];
    logic [16:0] expv;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic        prev_start = 1'b0;
    bit          gap_chk = 1'b0;
    int          last_start = -1;
    int          start_cyc = 0;
    int          n_starts = 0;
    int          fd_cnt = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (su | sd | sl | sr) begin
                chk("start_onehot", $countones({su, sd, sl, sr}), 1);
                chk("start_width", prev_start, 0);
                chk("start_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    expv = sb.pop_front();
                    chk("dispatch", {sdir, refx, refy}, expv);
                    cur_x = expv[14:7];
                    cur_y = expv[6:0];
                end
                if (gap_chk && last_start >= 0) chk("start_gap", cyc - last_start, 68);
                last_start = cyc;
                start_cyc  = cyc;
                n_starts++;
            end else if (busy) begin
                chk("refX_hold", refx, cur_x);
                chk("refY_hold", refy, cur_y);
            end
            if (fd) fd_cnt++;
            prev_start = su | sd | sl | sr;
        end
    end

    // Drive one request for one cycle; call just after a falling edge.
    task automatic push(input logic [1:0] d, input logic [7:0] x, input logic [6:0] y, input bit acc);
        rif.req_valid = 1'b1;
        rif.req_dir   = d;
        rif.req_x     = x;
        rif.req_y     = y;
        chk("req_ready", rif.req_ready, acc);
        if (acc) sb.push_back({d, x, y});
        @(negedge clock);
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (!busy && cnt == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, f0, s, ns;
        bit ok;
        rif.req_valid = 1'b0;
        rif.req_dir   = 2'd0;
        rif.req_x     = 8'd0;
        rif.req_y     = 7'd0;

        repeat (3) @(negedge clock);
        chk("rst_ready", rif.req_ready, 1);
        chk("rst_count", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_starts", {su, sd, sl, sr}, 0);
        chk("rst_ref", {refx, refy}, 0);
        chk("rst_flags", {fd, ae}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single request
        c  = cyc;
        f0 = fd_cnt;
        push(2'd0, 8'd40, 7'd100, 1);
        wait_idle(200);
        chk("t1_start_latency", start_cyc, c + 2);
        repeat (3) @(negedge clock);
        chk("t1_frame_done", fd_cnt - f0, 1);
        chk("t1_count", cnt, 0);

        // FIFO full with drawer stalled
        stall = 1'b1;
        push(2'd0, 8'd1, 7'd1, 1);
        push(2'd1, 8'd2, 7'd2, 1);
        push(2'd2, 8'd3, 7'd3, 1);
        push(2'd3, 8'd4, 7'd4, 1);
        push(2'd0, 8'd5, 7'd5, 1);
        chk("t2_count_full", cnt, 4);
        chk("t2_ready_full", rif.req_ready, 0);
        push(2'd1, 8'd6, 7'd6, 0);
        repeat (3) @(negedge clock);
        chk("t2_count_kept", cnt, 4);
        chk("t2_busy", busy, 1);
        stall = 1'b0;
        wait_idle(600);
        chk("t2_drained", sb.size(), 0);

        // Ordering and inter-draw gap
        repeat (3) @(negedge clock);
        ns         = n_starts;
        last_start = -1;
        gap_chk    = 1'b1;
        push(2'd3, 8'd10, 7'd11, 1);
        push(2'd1, 8'd20, 7'd21, 1);
        push(2'd2, 8'd30, 7'd31, 1);
        push(2'd0, 8'd50, 7'd51, 1);
        wait_idle(600);
        gap_chk = 1'b0;
        chk("t3_starts", n_starts - ns, 4);

        // Simultaneous push and pop with count=1 in IDLE
        repeat (3) @(negedge clock);
        push(2'd1, 8'd60, 7'd61, 1);
        repeat (10) @(negedge clock);
        push(2'd2, 8'd70, 7'd71, 1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_reached_idle", ok, 1);
        chk("t4_count_before", cnt, 1);
        push(2'd3, 8'd80, 7'd81, 1);
        chk("t4_count_pushpop", cnt, 1);
        chk("t4_busy", busy, 1);
        wait_idle(400);
        chk("t4_drained", sb.size(), 0);

        // ARM timeout
        repeat (3) @(negedge clock);
        nofall = 1'b1;
        chk("t5_err_before", ae, 0);
        push(2'd2, 8'd90, 7'd91, 1);
        push(2'd1, 8'd95, 7'd96, 1);
        @(negedge clock);
        #1;
        s = start_cyc;
        while (cyc < s + 4) @(negedge clock);
        chk("t5_err_early", ae, 0);
        @(negedge clock);
        chk("t5_err_set", ae, 1);
        chk("t5_idle", busy, 0);
        nofall = 1'b0;
        @(negedge clock);
        #1;
        chk("t5_next_start", start_cyc, s + 6);
        wait_idle(300);
        chk("t5_err_sticky", ae, 1);

        // Reset mid-draw
        repeat (3) @(negedge clock);
        stall = 1'b1;
        push(2'd0, 8'd1, 7'd2, 1);
        push(2'd1, 8'd3, 7'd4, 1);
        push(2'd2, 8'd5, 7'd6, 1);
        push(2'd3, 8'd7, 7'd8, 1);
        repeat (5) @(negedge clock);
        chk("t6_count_pre", cnt, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_count", cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", rif.req_ready, 1);
        chk("t6_ref", {refx, refy}, 0);
        chk("t6_flags", {fd, ae, su, sd, sl, sr}, 0);
        sb.delete();
        ns = n_starts;
        @(negedge clock);
        reset_n = 1'b1;
        stall   = 1'b0;
        repeat (20) @(negedge clock);
        chk("t6_no_start", n_starts - ns, 0);
        chk("t6_still_idle", busy, 0);
        push(2'd1, 8'd33, 7'd44, 1);
        wait_idle(200);
        chk("t6_restart", n_starts - ns, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
